// File: rtl/stopwatch_core_if.sv
// Signal bundle between the frequency divider / buttons and the stopwatch core.
// The slave side is the stopwatch; the master side drives divider and button levels.
interface stopwatch_core_if;
  logic       clk100Hz;
  logic       clk1000Hz;
  logic       start_stop;
  logic       clear;
  logic       running;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [7:0] cs_bcd;
  logic       wrap;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  modport slave (
    input  clk100Hz, clk1000Hz, start_stop, clear,
    output running, min_bcd, sec_bcd, cs_bcd, wrap, an, seg, dp
  );

  modport master (
    output clk100Hz, clk1000Hz, start_stop, clear,
    input  running, min_bcd, sec_bcd, cs_bcd, wrap, an, seg, dp
  );
endinterface

// File: rtl/stopwatch_core.sv
// MM:SS.cc stopwatch: synchronizes divider/button levels, runs a BCD count chain
// under an IDLE/RUN/PAUSE FSM, and scans six 7-segment digits.
module stopwatch_core (
  input  logic             clk,
  input  logic             rst,
  stopwatch_core_if.slave  sw
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  // bit order: {clear, start_stop, clk1000Hz, clk100Hz}
  logic [3:0] raw, s1, s2, s3;
  logic       ev100, ev1k, ss_ev, clr_ev;

  state_t     state_q, state_d;
  logic       zero, inc;
  logic [7:0] cs_q, sec_q, min_q;
  logic [7:0] cs_n, sec_n, min_n;
  logic       c0, c1, c2;
  logic       wrap_q;

  logic [2:0] idx_q;
  logic [3:0] digit;
  logic [5:0] an_q;
  logic [6:0] seg_q;
  logic       dp_q;

  assign raw = {sw.clear, sw.start_stop, sw.clk1000Hz, sw.clk100Hz};

  // Reset preloads all stages with the live level so release cannot fake an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= raw;
      s2 <= raw;
      s3 <= raw;
    end else begin
      s1 <= raw;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign ev100  = s2[0] ^ s3[0];
  assign ev1k   = s2[1] ^ s3[1];
  assign ss_ev  = s2[2] & ~s3[2];
  assign clr_ev = s2[3] & ~s3[3];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    zero    = 1'b0;
    case (state_q)
      IDLE:  if (ss_ev) state_d = RUN;
      RUN:   if (ss_ev) state_d = PAUSE;
      PAUSE: begin
        if (clr_ev) begin
          state_d = IDLE;
          zero    = 1'b1;
        end else if (ss_ev) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A tick landing on the same cycle as a start/stop edge is dropped.
  assign inc = (state_q == RUN) && ev100 && !ss_ev;

  function automatic logic [7:0] inc8(input logic [7:0] v, input logic [3:0] tmax);
    if (v[3:0] != 4'd9)      inc8 = {v[7:4], v[3:0] + 4'd1};
    else if (v[7:4] != tmax) inc8 = {v[7:4] + 4'd1, 4'd0};
    else                     inc8 = 8'h00;
  endfunction

  always_comb begin
    c0    = (cs_q == 8'h99);
    c1    = c0 && (sec_q == 8'h59);
    c2    = c1 && (min_q == 8'h59);
    cs_n  = inc8(cs_q, 4'd9);
    sec_n = inc8(sec_q, 4'd5);
    min_n = inc8(min_q, 4'd5);
  end

  always_ff @(posedge clk) begin
    if (rst || zero) begin
      cs_q   <= 8'h00;
      sec_q  <= 8'h00;
      min_q  <= 8'h00;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (inc) begin
        cs_q <= cs_n;
        if (c0) sec_q <= sec_n;
        if (c1) min_q <= min_n;
        wrap_q <= c2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       idx_q <= 3'd0;
    else if (ev1k) idx_q <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
  end

  always_comb begin
    digit = 4'd0;
    case (idx_q)
      3'd0: digit = cs_q[3:0];
      3'd1: digit = cs_q[7:4];
      3'd2: digit = sec_q[3:0];
      3'd3: digit = sec_q[7:4];
      3'd4: digit = min_q[3:0];
      3'd5: digit = min_q[7:4];
      default: digit = 4'd0;
    endcase
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= 6'b111110;
      seg_q <= 7'b1000000;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= ~(6'd1 << idx_q);
      seg_q <= seg7(digit);
      dp_q  <= !((idx_q == 3'd2) || (idx_q == 3'd4));
    end
  end

  assign sw.running = (state_q == RUN);
  assign sw.cs_bcd  = cs_q;
  assign sw.sec_bcd = sec_q;
  assign sw.min_bcd = min_q;
  assign sw.wrap    = wrap_q;
  assign sw.an      = an_q;
  assign sw.seg     = seg_q;
  assign sw.dp      = dp_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: reset, counting latency, FSM commands,
// wrap, tick/button collision, display scan and mid-count reset.
module tb_stopwatch_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nerr = 0;

  stopwatch_core_if sw();
  stopwatch_core dut (.clk(clk), .rst(rst), .sw(sw));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      sw.clk100Hz = ~sw.clk100Hz;
      step(3);
    end
  endtask

  task automatic press_ss();
    sw.start_stop = 1'b1;
    step(3);
    sw.start_stop = 1'b0;
    step(3);
  endtask

  task automatic chk_cnt(input string tag, input logic [7:0] m, input logic [7:0] s,
                         input logic [7:0] c);
    chk({tag, "_min"}, {24'd0, sw.min_bcd}, {24'd0, m});
    chk({tag, "_sec"}, {24'd0, sw.sec_bcd}, {24'd0, s});
    chk({tag, "_cs"},  {24'd0, sw.cs_bcd},  {24'd0, c});
  endtask

  logic [5:0] an_exp  [6] = '{6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111};
  logic [6:0] seg_exp [6] = '{7'b0000010, 7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
  logic       dp_exp  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    sw.clk100Hz = 1'b0; sw.clk1000Hz = 1'b0; sw.start_stop = 1'b0; sw.clear = 1'b0;
    #1;
    step(2);
    chk("rst_running", {31'd0, sw.running}, 32'd0);
    chk_cnt("rst", 8'h00, 8'h00, 8'h00);
    chk("rst_wrap", {31'd0, sw.wrap}, 32'd0);
    chk("rst_an", {26'd0, sw.an}, {26'd0, 6'b111110});
    chk("rst_seg", {25'd0, sw.seg}, {25'd0, 7'b1000000});
    chk("rst_dp", {31'd0, sw.dp}, 32'd1);
    rst = 1'b0;

    tick(10);
    chk_cnt("idle", 8'h00, 8'h00, 8'h00);
    chk("idle_running", {31'd0, sw.running}, 32'd0);
    chk("idle_an", {26'd0, sw.an}, {26'd0, 6'b111110});
    chk("idle_seg", {25'd0, sw.seg}, {25'd0, 7'b1000000});

    // start: state follows the button edge on the third edge
    sw.start_stop = 1'b1;
    step(2);
    chk("start_e2", {31'd0, sw.running}, 32'd0);
    step(1);
    chk("start_e3", {31'd0, sw.running}, 32'd1);
    sw.start_stop = 1'b0;
    step(3);

    sw.clk100Hz = ~sw.clk100Hz;
    step(2);
    chk("tick_e2", {24'd0, sw.cs_bcd}, 32'h00);
    step(1);
    chk("tick_e3", {24'd0, sw.cs_bcd}, 32'h01);
    tick(122);
    chk_cnt("cnt123", 8'h00, 8'h01, 8'h23);
    chk("cnt_running", {31'd0, sw.running}, 32'd1);

    // clear ignored while running
    sw.clear = 1'b1; step(3); sw.clear = 1'b0; step(3);
    chk("runclr_running", {31'd0, sw.running}, 32'd1);
    chk_cnt("runclr", 8'h00, 8'h01, 8'h23);

    press_ss();
    chk("pause_running", {31'd0, sw.running}, 32'd0);
    tick(5);
    chk_cnt("pause", 8'h00, 8'h01, 8'h23);

    // clear and start_stop together in PAUSE: clear wins
    sw.clear = 1'b1; sw.start_stop = 1'b1;
    step(3);
    sw.clear = 1'b0; sw.start_stop = 1'b0;
    step(3);
    chk("clrss_running", {31'd0, sw.running}, 32'd0);
    chk_cnt("clrss", 8'h00, 8'h00, 8'h00);
    tick(2);
    chk_cnt("clrss_idle", 8'h00, 8'h00, 8'h00);

    // tick colliding with RUN->PAUSE is dropped
    press_ss();
    tick(2);
    chk("coll_pre", {24'd0, sw.cs_bcd}, 32'h02);
    sw.clk100Hz = ~sw.clk100Hz; sw.start_stop = 1'b1;
    step(3);
    chk("coll_running", {31'd0, sw.running}, 32'd0);
    chk("coll_cs", {24'd0, sw.cs_bcd}, 32'h02);
    sw.start_stop = 1'b0;
    step(3);

    // wrap: preload 59:59.99 while paused
    force dut.min_q = 8'h59; force dut.sec_q = 8'h59; force dut.cs_q = 8'h99;
    step(1);
    release dut.min_q; release dut.sec_q; release dut.cs_q;
    step(1);
    chk_cnt("preload", 8'h59, 8'h59, 8'h99);
    press_ss();
    chk("wrap_pre", {31'd0, sw.wrap}, 32'd0);
    sw.clk100Hz = ~sw.clk100Hz;
    step(3);
    chk_cnt("wrap", 8'h00, 8'h00, 8'h00);
    chk("wrap_pulse", {31'd0, sw.wrap}, 32'd1);
    chk("wrap_running", {31'd0, sw.running}, 32'd1);
    step(1);
    chk("wrap_clear", {31'd0, sw.wrap}, 32'd0);
    step(1);
    press_ss();

    // scan at 12:34.56
    force dut.min_q = 8'h12; force dut.sec_q = 8'h34; force dut.cs_q = 8'h56;
    step(1);
    release dut.min_q; release dut.sec_q; release dut.cs_q;
    step(2);
    chk_cnt("scan", 8'h12, 8'h34, 8'h56);
    chk("scan0_an", {26'd0, sw.an}, {26'd0, an_exp[0]});
    chk("scan0_seg", {25'd0, sw.seg}, {25'd0, seg_exp[0]});
    chk("scan0_dp", {31'd0, sw.dp}, {31'd0, dp_exp[0]});
    for (int k = 1; k <= 6; k++) begin
      int i;
      i = k % 6;
      sw.clk1000Hz = ~sw.clk1000Hz;
      step(3);
      chk($sformatf("scan%0d_hold", k), {26'd0, sw.an}, {26'd0, an_exp[k-1]});
      step(1);
      chk($sformatf("scan%0d_an", k), {26'd0, sw.an}, {26'd0, an_exp[i]});
      chk($sformatf("scan%0d_seg", k), {25'd0, sw.seg}, {25'd0, seg_exp[i]});
      chk($sformatf("scan%0d_dp", k), {31'd0, sw.dp}, {31'd0, dp_exp[i]});
    end

    // reset mid-count
    press_ss();
    tick(3);
    chk_cnt("midrun", 8'h12, 8'h34, 8'h59);
    rst = 1'b1;
    step(1);
    chk_cnt("midrst", 8'h00, 8'h00, 8'h00);
    chk("midrst_running", {31'd0, sw.running}, 32'd0);
    chk("midrst_an", {26'd0, sw.an}, {26'd0, 6'b111110});
    rst = 1'b0;
    step(3);
    tick(1);
    chk_cnt("postrst", 8'h00, 8'h00, 8'h00);
    chk("postrst_running", {31'd0, sw.running}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Timekeeping and display stage fed by the frequency divider. It samples the divider's 100 Hz and 1000 Hz outputs as data in the system clock domain and turns each transition into a single-cycle tick. It runs an MM:SS.cc stopwatch with start/stop and clear buttons. It drives a 6-digit multiplexed 7-segment display.

## Interface
Parameters:
- none; the count range is fixed at 00:00.00–59:59.99 and the display at 6 digits

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- clk100Hz  in  1  divider output, treated as data; every transition is one count tick
- clk1000Hz  in  1  divider output, treated as data; every transition advances the display scan
- start_stop  in  1  debounced button level; its rising edge is the command
- clear  in  1  debounced button level; its rising edge is the command
- running  out  1  high while in RUN
- min_bcd  out  8  minutes, two BCD digits [7:4] tens, [3:0] units
- sec_bcd  out  8  seconds, two BCD digits
- cs_bcd  out  8  centiseconds, two BCD digits
- wrap  out  1  one-cycle pulse on 59:59.99 → 00:00.00
- an  out  6  digit enables, active-low, one-hot
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

## Operation
- **Input conditioning:** all four inputs pass through a 2-flop synchronizer (s1, s2) into a history flop s3. The event is s2^s3 for the clocks and s2&~s3 for the buttons.
- **Reset loading:** while rst is high, s1, s2 and s3 of every input load the raw input value. No spurious edge or tick can appear after reset release.
- **FSM states:** IDLE (reset state, count zero), RUN, PAUSE.
  - IDLE: a start_stop edge goes to RUN. A clear edge is a no-op.
  - RUN: a start_stop edge goes to PAUSE. A clear edge is ignored.
  - PAUSE: a clear edge goes to IDLE and zeroes all counters. Otherwise a start_stop edge goes to RUN.
  - Clear and start_stop edges in the same cycle in PAUSE: clear wins and start_stop is discarded.
- **Counting:** increment iff state==RUN, a 100 Hz event occurs, and there is no start_stop edge that cycle. A tick coinciding with RUN→PAUSE is dropped. A tick coinciding with PAUSE→RUN does not count.
- **BCD chain:** cs units 9→0 carries to cs tens; cs tens 9→0 carries to sec units. sec units 9→0 carries to sec tens; sec tens 5→0 carries to min units. min units 9→0 carries to min tens; min tens 5→0 wraps.
  - 59:59.99 + tick → 00:00.00, wrap=1 for that one cycle, state stays RUN.
  - Digits are never outside 0–9, and tens of sec/min are never above 5.
- **Display scan:** a 3-bit index advances 0→5→0 on each 1000 Hz event, in every state.
- **Digit map:** 0 = cs units, 1 = cs tens, 2 = sec units, 3 = sec tens, 4 = min units, 5 = min tens.
- **Display registers:** an, seg and dp are registered from the index and the current counters.
  - an[i]=0 only for the selected digit.
  - dp=0 on digits 2 and 4, 1 elsewhere.
- **Segment codes (gfedcba):** 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

## Timing
- Reset values at the first edge with rst=1:
  - state IDLE, running=0, all BCD outputs 0x00, wrap=0
  - scan index 0, an=111110, seg=1000000, dp=1
- Reset mid-count: all of the above on the next edge; the count is lost.
- Tick latency: a raw transition sampled at edge E0 gives event high after E2. The counter changes at E3, 3 clk edges in total.
  - Button-to-state latency is the same 3 edges.
  - running follows state with no extra delay.
- Display latency: the index changes at E3 after a 1000 Hz transition. an, seg and dp change at E4.
  - Displayed digit values lag the counters by 1 cycle.
- Events need at least 3 clk cycles between input transitions; the divider guarantees far more.

## Test plan
- **Reset and idle:** rst high for 2 cycles, then low; toggle clk100Hz 10 times with no button → counters stay 00:00.00, running=0, an=111110, seg=1000000.
- **Start and count:** start_stop edge, then 123 clk100Hz transitions → running=1, cs_bcd=0x23, sec_bcd=0x01, min_bcd=0x00. The counter changes exactly 3 edges after each transition.
- **Pause, resume, clear:** pause and apply 5 ticks → no change. Assert clear in the same cycle as start_stop → IDLE with counters 0. A clear edge during RUN → ignored.
- **Wrap:** run to 59:59.99, then one tick → 00:00.00, wrap high for exactly 1 cycle, running stays 1.
- **Tick collision:** a tick and a start_stop edge in the same cycle in RUN → PAUSE with the count unchanged.
- **Scan at 12:34.56:** 6 clk1000Hz transitions → an cycles 111110…011111. seg shows 6, 5, 4, 3, 2, 1 (0000010, 0010010, 0011001, 0110000, 0100100, 1111001). dp is low only on an[2] and an[4]; outputs change 4 edges after each transition.
